// File: rtl/mul_pkg.sv
// Shared types and constants for the multiply-select consumer path.
// Holds the beat/width constants, the collector FSM state type and the buffer entry layout.
// Optional MUL_CHECK_EN adds a per-entry consistency error bit to the entry layout.
package mul_pkg;

  localparam int BEATS  = 4;
  localparam int DATA_W = 11;
  localparam int BASE_W = 8;
  localparam int SUM_W  = 13;

  typedef enum logic [1:0] {
    COL_WAIT = 2'd0,
    COL_B1   = 2'd1,
    COL_B2   = 2'd2,
    COL_B3   = 2'd3
  } mul_col_state_t;

  typedef struct packed {
`ifdef MUL_CHECK_EN
    logic              err;
`endif
    logic [SUM_W-1:0]  sum;
    logic [BASE_W-1:0] base;
  } mul_entry_t;

endpackage

// File: rtl/mul_frame_fifo.sv
// Purpose : 2-entry synchronous FIFO, head shown combinationally from storage.
// Latency : an entry pushed at edge N is at the head after edge N when the FIFO was empty.
// Backpr. : push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
// Ports   : clk/rst (async active-low), push/push_dat, pop, head, full, empty.
module mul_frame_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // When full, the write slot is the head slot being popped, so the overwrite is safe.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/mul_frame_collect.sv
// Purpose : assemble 4-beat (d,3d,7d,8d) frames, reduce to base and sum, buffer 2 frames for a valid/ready sink.
// Latency : o_valid rises the cycle after the beat-3 edge when the buffer was empty.
// Backpr. : o_ready=0 holds the head; a frame completing into a full buffer (no pop) is dropped and sets ovf.
// Ports   : clk, rst (async active-low), in_grant/in_data upstream beats; o_valid/o_ready/o_base/o_sum/o_err
//           head frame; ovf sticky drop flag; frame_cnt saturating count of buffered frames.
// Config  : define MUL_CHECK_EN to build the multiple-consistency check driving o_err.
module mul_frame_collect
  import mul_pkg::*;
#(
  parameter int SUM_W = mul_pkg::SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_grant,
  input  logic [DATA_W-1:0] in_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [BASE_W-1:0] o_base,
  output logic [SUM_W-1:0]  o_sum,
  output logic              o_err,
  output logic              ovf,
  output logic [15:0]       frame_cnt
);

  localparam int ENTRY_W = $bits(mul_entry_t);

  mul_col_state_t    state;
  logic [DATA_W-1:0] b0, b1, b2;
  logic              complete;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [SUM_W-1:0]  sum_full;
  mul_entry_t        new_entry;
  mul_entry_t        head_entry;
  mul_entry_t        last_entry;
  mul_entry_t        shown;
  logic [ENTRY_W-1:0] head_bits;

  // Grant wins in every state: it restarts the frame, discarding any partial one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COL_WAIT;
      b0    <= '0;
      b1    <= '0;
      b2    <= '0;
    end else if (in_grant) begin
      b0    <= in_data;
      state <= COL_B1;
    end else begin
      case (state)
        COL_B1:  begin b1 <= in_data; state <= COL_B2;   end
        COL_B2:  begin b2 <= in_data; state <= COL_B3;   end
        COL_B3:  state <= COL_WAIT;
        default: state <= COL_WAIT;
      endcase
    end
  end

  // Beat 3 is never stored; it is consumed straight from in_data at completion.
  assign complete = (state == COL_B3) && !in_grant;
  assign sum_full = SUM_W'(b0) + SUM_W'(b1) + SUM_W'(b2) + SUM_W'(in_data);

  always_comb begin
    new_entry      = '0;
    new_entry.sum  = sum_full;
    new_entry.base = b0[BASE_W-1:0];
`ifdef MUL_CHECK_EN
    new_entry.err  = (b0[DATA_W-1:BASE_W] != '0)
                  || (b1      != DATA_W'(b0 * 3))
                  || (b2      != DATA_W'(b0 * 7))
                  || (in_data != DATA_W'(b0 * 8));
`endif
  end

  assign o_valid = !fifo_empty;
  assign pop     = o_valid && o_ready;
  assign push    = complete && (!fifo_full || pop);

  mul_frame_fifo #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (new_entry),
    .pop      (pop),
    .head     (head_bits),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign head_entry = mul_entry_t'(head_bits);

  // FIFO storage slots do not hold the last-popped value at the head, so
  // the most recently shown head is kept separately for the empty case.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_entry <= '0;
      ovf        <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (!fifo_empty) begin
        last_entry <= head_entry;
      end
      if (complete && !push) begin
        ovf <= 1'b1;
      end
      if (push && (frame_cnt != 16'hFFFF)) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign shown  = fifo_empty ? last_entry : head_entry;
  assign o_base = shown.base;
  assign o_sum  = shown.sum;
`ifdef MUL_CHECK_EN
  assign o_err  = shown.err;
`else
  assign o_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mul_frame_collect.sv
module tb_mul_frame_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_grant;
  logic [10:0] in_data;
  logic        o_valid;
  logic        o_ready;
  logic [7:0]  o_base;
  logic [12:0] o_sum;
  logic        o_err;
  logic        ovf;
  logic [15:0] frame_cnt;

  mul_frame_collect #(.SUM_W(13)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_grant  (in_grant),
    .in_data   (in_data),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_base    (o_base),
    .o_sum     (o_sum),
    .o_err     (o_err),
    .ovf       (ovf),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int base;
    int sum;
    bit err;
  } frm_t;

  // Reference model: queue of buffered frames, list of beats since last grant.
  frm_t exp_q[$];
  int   beats[$];
  bit   m_ovf;
  int   m_cnt;
  frm_t shown;

  function automatic frm_t mk(input int a0, input int a1, input int a2, input int a3);
    frm_t f;
    f.sum  = a0 + a1 + a2 + a3;
    f.base = a0 % 256;
`ifdef MUL_CHECK_EN
    f.err  = (a0 > 255) || (a1 != ((3 * a0) % 2048)) || (a2 != ((7 * a0) % 2048))
          || (a3 != ((8 * a0) % 2048));
`else
    f.err  = 1'b0;
`endif
    return f;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    beats.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
    shown = '{0, 0, 1'b0};
  endtask

  // Drive one cycle (called at a negedge), advance the model, return at the next negedge.
  task automatic step(input bit g, input int d, input bit r);
    bit   pop;
    bit   room;
    bit   done;
    frm_t f;
    in_grant = g;
    in_data  = d[10:0];
    o_ready  = r;
    pop  = (exp_q.size() > 0) && r;
    room = (exp_q.size() < 2) || pop;
    done = 1'b0;
    if (g) begin
      beats.delete();
      beats.push_back(d % 2048);
    end else if (beats.size() > 0) begin
      beats.push_back(d % 2048);
      if (beats.size() == 4) begin
        f = mk(beats[0], beats[1], beats[2], beats[3]);
        done = 1'b1;
        beats.delete();
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (done) begin
      if (room) begin
        exp_q.push_back(f);
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) shown = exp_q[0];
  endtask

  task automatic frame(input int d, input bit r);
    step(1'b1, d, r);
    step(1'b0, 3 * d, r);
    step(1'b0, 7 * d, r);
    step(1'b0, 8 * d, r);
  endtask

  task automatic test_reset();
    rst = 1'b0; in_grant = 1'b0; in_data = '0; o_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_base !== 8'd0 || o_sum !== 13'd0 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b base=%0d sum=%0d err=%0b expected 0 0 0 0",
               o_valid, o_base, o_sum, o_err);
    end
    checks++;
    if (ovf !== 1'b0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_status: ovf=%0b frame_cnt=%0d expected 0 0", ovf, frame_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    frame(143, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_base !== 8'd143 || o_sum !== 13'd2717 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_frame: valid=%0b base=%0d sum=%0d err=%0b expected 1 143 2717 0",
               o_valid, o_base, o_sum, o_err);
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL basic_cnt: frame_cnt=%0d expected 1", frame_cnt);
    end
    step(1'b0, 0, 1'b1);
    checks++;
    if (o_valid !== 1'b0 || o_base !== 8'd143 || o_sum !== 13'd2717) begin
      errors++;
      $display("FAIL basic_hold: valid=%0b base=%0d sum=%0d expected 0 143 2717",
               o_valid, o_base, o_sum);
    end
  endtask

  task automatic test_back_to_back();
    int mult[4];
    int vcount;
    int sums[2];
    int idx[2];
    int dd;
    mult = '{1, 3, 7, 8};
    vcount = 0;
    sums = '{0, 0};
    idx  = '{0, 0};
    for (int i = 0; i < 12; i++) begin
      dd = (i < 8) ? ((i < 4) ? 128 : 255) * mult[i % 4] : 0;
      step((i % 4 == 0) && (i < 8), dd, 1'b1);
      if (o_valid === 1'b1) begin
        if (vcount < 2) begin
          sums[vcount] = int'(o_sum);
          idx[vcount]  = i;
        end
        vcount++;
      end
    end
    checks++;
    if (vcount != 2) begin
      errors++;
      $display("FAIL b2b_pulses: valid cycles=%0d expected 2", vcount);
    end
    checks++;
    if (sums[0] != 2432 || sums[1] != 4845) begin
      errors++;
      $display("FAIL b2b_order: sums=%0d,%0d expected 2432,4845", sums[0], sums[1]);
    end
    checks++;
    if (idx[1] - idx[0] != 4 || idx[0] != 3) begin
      errors++;
      $display("FAIL b2b_timing: valid at cycles %0d,%0d expected 3,7", idx[0], idx[1]);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ovf: ovf=%0b expected 0", ovf);
    end
  endtask

  task automatic test_overflow();
    int cnt0;
    cnt0 = m_cnt;
    frame(10, 1'b0);
    frame(20, 1'b0);
    frame(30, 1'b0);
    step(1'b0, 0, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || ovf !== 1'b1 || frame_cnt !== 16'(cnt0 + 2)) begin
      errors++;
      $display("FAIL ovf_state: valid=%0b ovf=%0b frame_cnt=%0d expected 1 1 %0d",
               o_valid, ovf, frame_cnt, cnt0 + 2);
    end
    checks++;
    if (o_sum !== 13'd190 || o_base !== 8'd10) begin
      errors++;
      $display("FAIL ovf_head0: sum=%0d base=%0d expected 190 10", o_sum, o_base);
    end
    step(1'b0, 0, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 13'd380) begin
      errors++;
      $display("FAIL ovf_head1: valid=%0b sum=%0d expected 1 380", o_valid, o_sum);
    end
    step(1'b0, 0, 1'b1);
    checks++;
    if (o_valid !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain: valid=%0b ovf=%0b expected 0 1", o_valid, ovf);
    end
  endtask

  task automatic test_resync();
    int cnt0;
    cnt0 = m_cnt;
    step(1'b1, 50, 1'b1);
    step(1'b0, 150, 1'b1);
    step(1'b1, 60, 1'b1);
    step(1'b0, 180, 1'b1);
    step(1'b0, 420, 1'b1);
    step(1'b0, 480, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 13'd1140 || o_base !== 8'd60 || frame_cnt !== 16'(cnt0 + 1)) begin
      errors++;
      $display("FAIL resync: valid=%0b sum=%0d base=%0d cnt=%0d expected 1 1140 60 %0d",
               o_valid, o_sum, o_base, frame_cnt, cnt0 + 1);
    end
    step(1'b0, 0, 1'b1);
  endtask

  task automatic test_check();
    bit exp_err;
`ifdef MUL_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    step(1'b1, 143, 1'b1);
    step(1'b0, 429, 1'b1);
    step(1'b0, 1000, 1'b1);
    step(1'b0, 1144, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 13'd2716 || o_err !== exp_err) begin
      errors++;
      $display("FAIL check_corrupt: valid=%0b sum=%0d err=%0b expected 1 2716 %0b",
               o_valid, o_sum, o_err, exp_err);
    end
    step(1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    frame(40, 1'b0);
    step(1'b1, 70, 1'b0);
    step(1'b0, 210, 1'b0);
    rst = 1'b0;
    #2;
    model_clear();
    checks++;
    if (o_valid !== 1'b0 || o_base !== 8'd0 || o_sum !== 13'd0 || o_err !== 1'b0 ||
        ovf !== 1'b0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: valid=%0b base=%0d sum=%0d err=%0b ovf=%0b cnt=%0d expected all 0",
               o_valid, o_base, o_sum, o_err, ovf, frame_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 630, 1'b1);
    frame(5, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 13'd95 || o_base !== 8'd5 || frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL reset_restart: valid=%0b sum=%0d base=%0d cnt=%0d expected 1 95 5 1",
               o_valid, o_sum, o_base, frame_cnt);
    end
  endtask

  task automatic test_random();
    int phase;
    int d;
    int dd;
    int mult[4];
    bit g;
    mult = '{1, 3, 7, 8};
    phase = 0;
    d = 0;
    for (int i = 0; i < 600; i++) begin
      g = 1'b0;
      if (phase == 0) begin
        if ($urandom_range(0, 7) != 0) begin
          g = 1'b1;
          d = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 255));
          dd = d;
          phase = 1;
        end else begin
          dd = int'($urandom_range(0, 2047));
        end
      end else begin
        dd = (d * mult[phase]) % 2048;
        if ($urandom_range(0, 9) == 0) dd = int'($urandom_range(0, 2047));
        if ($urandom_range(0, 19) == 0) begin
          g = 1'b1;
          d = int'($urandom_range(0, 255));
          dd = d;
          phase = 0;
        end
        phase = (phase + 1) % 4;
      end
      step(g, dd, $urandom_range(0, 9) < 7);
      checks++;
      if (o_valid !== (exp_q.size() > 0) || o_base !== 8'(shown.base) ||
          o_sum !== 13'(shown.sum) || o_err !== shown.err) begin
        errors++;
        $display("FAIL rand_head[%0d]: valid=%0b base=%0d sum=%0d err=%0b expected %0b %0d %0d %0b",
                 i, o_valid, o_base, o_sum, o_err, exp_q.size() > 0, shown.base, shown.sum, shown.err);
      end
      checks++;
      if (ovf !== m_ovf || frame_cnt !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL rand_status[%0d]: ovf=%0b cnt=%0d expected %0b %0d",
                 i, ovf, frame_cnt, m_ovf, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_resync();
    test_check();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
